// File: rtl/mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : mdu_div_iter
// Purpose  : Multi-cycle radix-2 restoring divider for RV64 M-extension
//            DIV/DIVU/REM/REMU and their W variants.
//            Divide-by-zero and signed overflow finish in one cycle. Other
//            ops run N shift/subtract steps (N = 64, or 32 for W), then one
//            sign-fix cycle.
// Ports    : clock, reset      - core clock, asynchronous active-high reset
//            flush             - synchronous kill of any in-flight op
//            in_valid/in_ready - issue-side handshake
//            is_signed/is_rem/is_word, src1 (dividend), src2 (divisor)
//            out_valid/out_ready, result - writeback-side handshake
// Revision : 1.0 - initial release
// ============================================================================
module mdu_div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [6:0]      cnt_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvs_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            is_rem_q;
    logic            is_word_q;
    logic [XLEN-1:0] result_q;
    logic            out_valid_q;

    // Operand preparation (evaluated every cycle, used only on accept)
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
    logic            sign1, sign2, div_zero, ovf;
    logic [XLEN-1:0] spec_sel, spec_res_d;
    logic [XLEN-1:0] quo_init_d;
    logic [6:0]      cnt_init_d;

    always_comb begin
        if (is_word) begin
            a_ext = {{32{is_signed & src1[31]}}, src1[31:0]};
            b_ext = {{32{is_signed & src2[31]}}, src2[31:0]};
        end else begin
            a_ext = src1;
            b_ext = src2;
        end
        sign1 = is_signed & a_ext[XLEN-1];
        sign2 = is_signed & b_ext[XLEN-1];
        mag_a = sign1 ? (~a_ext + 64'd1) : a_ext;
        mag_b = sign2 ? (~b_ext + 64'd1) : b_ext;

        div_zero = (b_ext == '0);
        // After sign extension, the most negative W value is 0xFFFF_FFFF_8000_0000
        ovf = is_signed && (b_ext == '1) &&
              (is_word ? (a_ext == 64'hFFFF_FFFF_8000_0000)
                       : (a_ext == 64'h8000_0000_0000_0000));

        if (div_zero)
            spec_sel = is_rem ? a_ext : '1;
        else
            spec_sel = is_rem ? '0 : a_ext;
        spec_res_d = is_word ? {{32{spec_sel[31]}}, spec_sel[31:0]} : spec_sel;

        // W ops keep the 32-bit dividend in the top half of quo so that it
        // feeds the remainder after exactly 32 shifts.
        quo_init_d = is_word ? {mag_a[31:0], 32'd0} : mag_a;
        cnt_init_d = is_word ? 7'd32 : 7'd64;
    end

    // One restoring step: shift {rem, quo} left, trial-subtract divisor.
    // The shifted remainder can need 65 bits, so compare at that width.
    logic [XLEN:0]   shifted;
    logic            borrow;
    logic [XLEN-1:0] rem_d, quo_d;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        borrow  = (shifted < {1'b0, dvs_q});
        rem_d   = borrow ? shifted[XLEN-1:0] : (shifted[XLEN-1:0] - dvs_q);
        quo_d   = {quo_q[XLEN-2:0], ~borrow};
    end

    // Sign fix-up and result selection
    logic [XLEN-1:0] fix_q_val, fix_r_val, fix_sel, fix_res_d;

    always_comb begin
        fix_q_val = q_neg_q ? (~quo_q + 64'd1) : quo_q;
        fix_r_val = r_neg_q ? (~rem_q + 64'd1) : rem_q;
        fix_sel   = is_rem_q ? fix_r_val : fix_q_val;
        fix_res_d = is_word_q ? {{32{fix_sel[31]}}, fix_sel[31:0]} : fix_sel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
            is_word_q   <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        is_rem_q  <= is_rem;
                        is_word_q <= is_word;
                        q_neg_q   <= sign1 ^ sign2;
                        r_neg_q   <= sign1;
                        if (div_zero || ovf) begin
                            result_q    <= spec_res_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= quo_init_d;
                            dvs_q   <= mag_b;
                            cnt_q   <= cnt_init_d;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= fix_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_div_iter
// Purpose  : Self-checking bench for mdu_div_iter. Expected results come
//            from a reference model built on native SV division; they are
//            queued when an op is driven and compared when out_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic        is_rem = 1'b0;
    logic        is_word = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    always #5 clk = ~clk;

    mdu_div_iter #(.XLEN(64)) dut (
        .clock     (clk),
        .reset     (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .is_rem    (is_rem),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit s, input bit r, input bit w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, res32;
        logic [63:0] q64, r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            res32 = r ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; r64 = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = '0;
            end else if (s) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            return r ? r64 : q64;
        end
    endfunction

    function automatic int model_lat(input bit s, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
        if (w) begin
            if (b[31:0] == 32'd0) return 1;
            if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 34;
        end
        if (b == 64'd0) return 1;
        if (s && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
        return 66;
    endfunction

    // Present one op, wait for its result and compare with the scoreboard.
    task automatic run_op(input string tag, input bit s, input bit r, input bit w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        logic [63:0] e;
        int el;
        @(negedge clk);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; is_signed = s; is_rem = r; is_word = w;
        src1 = a; src2 = b;
        exp_q.push_back(exp);
        lat_q.push_back(exp_lat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!out_valid) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk(tag, result, e);
            chk({tag, "_lat"}, 64'(lat), 64'(el));
        end
        // out_ready is high, so the handshake completes at the next edge
        @(posedge clk);
        #1;
    endtask

    task automatic run_model(input string tag, input bit s, input bit r, input bit w,
                             input logic [63:0] a, input logic [63:0] b);
        run_op(tag, s, r, w, a, b, model(s, r, w, a, b), model_lat(s, w, a, b));
    endtask

    initial begin
        logic [63:0] held;
        int seen;
        // Reset state
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Test plan vectors with constant expectations
        run_op("div_100_7",  1, 0, 0, 64'd100, 64'd7, 64'd14, 66);
        run_op("rem_100_7",  1, 1, 0, 64'd100, 64'd7, 64'd2, 66);
        run_op("div_m7_2",   1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem_m7_2",   1, 1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("rem_7_m2",   1, 1, 0, 64'd7, -64'sd2, 64'd1, 66);
        run_op("divu_5_0",   0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("remu_5_0",   0, 1, 0, 64'd5, 64'd0, 64'd5, 1);
        run_op("divw_x_0",   1, 0, 1, 64'h1_0000_0003, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("div_ovf",    1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
        run_op("rem_ovf",    1, 1, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
        run_op("divw_ovf",   1, 0, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
        run_op("divuw_fffe", 0, 0, 1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("remuw_9_4",  0, 1, 1, 64'h1_0000_0009, 64'd4, 64'd1, 34);

        // Randomised ops against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a, b;
            bit s, r, w;
            a = {$urandom, $urandom};
            b = (i % 3 == 0) ? 64'($urandom_range(1, 1000)) : {$urandom, $urandom} >> $urandom_range(0, 60);
            if (b == 64'd0) b = 64'd3;
            s = i[0]; r = i[1]; w = i[2];
            run_model($sformatf("rand%0d", i), s, r, w, a, b);
        end

        // Back-pressure: result and in_ready held while out_ready is low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; is_signed = 0; is_rem = 0; is_word = 0;
        src1 = 64'd1000; src2 = 64'd9;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 200) begin
            @(posedge clk);
            #1 seen++;
        end
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        held = result;
        chk("bp_result", held, 64'd111);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_result", result, 64'd111);
            chk("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_after_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_after_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush at CALC cycle 10
        @(negedge clk);
        in_valid = 1'b1; is_signed = 1; is_rem = 0; is_word = 0;
        src1 = 64'd5000; src2 = 64'd7;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        chk("flush_no_output", 64'(seen), 64'd0);
        run_op("post_flush", 1, 1, 0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 66);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; is_signed = 0; is_rem = 0; is_word = 0;
        src1 = 64'd77; src2 = 64'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_result", result, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        run_op("post_rst", 0, 0, 0, 64'd77, 64'd5, 64'd15, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
